vga_fb_arbiter: RTL

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 19 +
 rtl/vga_wr_fifo.sv | 51 +++++
 rtl/vga_fb_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared types for the framebuffer arbiter: display geometry defaults,
// arbiter state encoding and the buffered write entry.
package vga_pkg;
  localparam int HVID_DFLT = 640;
  localparam int VVID_DFLT = 480;
  localparam int FB_ADDR_W = 19;
  localparam int FB_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [FB_ADDR_W-1:0] addr;
    logic [FB_DATA_W-1:0] data;
  } wr_entry_t;
endpackage

// File: rtl/vga_wr_fifo.sv
// Small write-buffer FIFO holding pending framebuffer writes.
// DEPTH must be a power of two; reset flushes all entries.
module vga_wr_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk_25,
  input  logic                   n_rst,
  input  logic                   push,
  input  logic                   pop,
  input  wr_entry_t              din,
  output wr_entry_t              head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  wr_entry_t      mem [DEPTH];
  logic [PW-1:0]  wp, rp;
  logic [PW:0]    cnt;
  logic           do_push, do_pop;

  assign full    = (cnt == (PW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign head    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk_25) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: display reads own the RAM while video_on,
// writes are buffered and drained during blanking. FB_STALL_CNT_EN adds stall_cnt.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int HVID       = HVID_DFLT,
  parameter int VVID       = VVID_DFLT,
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk_25,
  input  logic              n_rst,
  input  logic              video_on,
  input  logic [9:0]        x_coordinate,
  input  logic [9:0]        y_coordinate,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic              wr_oob
`ifdef FB_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);
  localparam int          STAGES  = 2;
  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned FB_SIZE = HVID * VVID;

  arb_state_t         state, state_nx;
  wr_entry_t          wr_ent, head;
  logic               push, pop, full, empty, head_oob;
  logic [CW-1:0]      count;
  logic [ADDR_W-1:0]  disp_addr;
  logic [STAGES:1]    vld_pipe;

  // wr_ready is gated by reset so nothing is accepted while n_rst is low
  assign wr_ready   = n_rst && !full;
  assign push       = wr_valid && wr_ready;
  assign pop        = (state == DRAIN) && !video_on && !empty;
  assign head_oob   = 32'(head.addr) >= FB_SIZE;
  assign wr_ent     = '{addr: wr_addr, data: wr_data};
  assign disp_addr  = ADDR_W'(y_coordinate) * ADDR_W'(HVID) + ADDR_W'(x_coordinate);

  vga_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_25 (clk_25),
    .n_rst  (n_rst),
    .push   (push),
    .pop    (pop),
    .din    (wr_ent),
    .head   (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (push) state_nx = video_on ? HOLD : DRAIN;
      HOLD:    if (!video_on) state_nx = DRAIN;
      DRAIN: begin
        if (video_on) state_nx = HOLD;
        else if (pop && count == CW'(1) && !push) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // out-of-range entries still pop, but never reach the RAM
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (video_on) begin
      mem_addr = disp_addr;
    end else if (pop && !head_oob) begin
      mem_we    = 1'b1;
      mem_addr  = head.addr;
      mem_wdata = head.data;
    end
  end

  // RAM returns data one cycle after the address; capture it one cycle later
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) begin
      vld_pipe <= '0;
      pix_data <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], video_on};
      pix_data <= vld_pipe[1] ? mem_rdata : '0;
    end
  end
  assign pix_valid = vld_pipe[STAGES];

  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst)                wr_oob <= 1'b0;
    else if (pop && head_oob)  wr_oob <= 1'b1;
  end

`ifdef FB_STALL_CNT_EN
  always_ff @(posedge clk_25 or negedge n_rst) begin
    if (!n_rst) stall_cnt <= '0;
    else if (wr_valid && !wr_ready && stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
  end
`endif
endmodule
